apa102_in: RTL and testbench

//  APA102 receiver: samples an external APA102 data/clock pair with the system clock.

---
 rtl/apa102_in_if.sv | 35 +++
 rtl/apa102_in.sv | 228 ++++++++++++++++++++++
 tb/tb_apa102_in.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/apa102_in_if.sv
`default_nettype none
// ============================================================================
// Module      : apa102_in_if
// Description : Configuration, APA102 line and pixel-memory write bus of the
//               APA102 receiver. The master side is the receiver itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface apa102_in_if #(
    parameter int ADDRESS_BUS_WIDTH = 16
) ();
    logic [15:0]                  start_address;
    logic [15:0]                  word_count;
    logic                         data_in;
    logic                         clock_in;
    logic [ADDRESS_BUS_WIDTH-1:0] write_address;
    logic [15:0]                  write_data;
    logic                         write_strobe;
    logic                         frame_done;
    logic                         frame_error;
    logic [15:0]                  pixel_count;
    logic                         overflow;

    modport master (
        input  start_address, word_count, data_in, clock_in,
        output write_address, write_data, write_strobe,
               frame_done, frame_error, pixel_count, overflow
    );

    modport slave (
        output start_address, word_count, data_in, clock_in,
        input  write_address, write_data, write_strobe,
               frame_done, frame_error, pixel_count, overflow
    );
endinterface
`default_nettype wire

// File: rtl/apa102_in.sv
`default_nettype none
// ============================================================================
// Module      : apa102_in
// Description : APA102 receiver. Oversamples the APA102 data/clock pair,
//               decodes start / LED / end frames and packs the B,G,R bytes
//               into 16-bit words written to pixel memory.
// Revision    : 1.0 - initial release
// ============================================================================
module apa102_in #(
    parameter int ADDRESS_BUS_WIDTH = 16,
    parameter int IDLE_TIMEOUT      = 1024   // must be >= 4 so it never overlaps byte packing
) (
    input  logic        clk,
    input  logic        rst,
    apa102_in_if.master bus
);
    localparam int                    c_idle_w   = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [c_idle_w-1:0]   c_idle_max = c_idle_w'(IDLE_TIMEOUT);
    localparam logic [c_idle_w-1:0]   c_idle_pre = c_idle_w'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_HUNT  = 2'd0,
        ST_START = 2'd1,
        ST_FRAME = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    // Line conditioning
    logic r_data_meta, r_data_sync, r_clk_meta, r_clk_sync, r_clk_prev;

    // Decoder / packer state
    state_t                       r_state;
    logic [4:0]                   r_zero_cnt;
    logic [4:0]                   r_bit_cnt;
    logic [30:0]                  r_sr;
    logic [c_idle_w-1:0]          r_idle;
    logic [23:0]                  r_pix;
    logic [1:0]                   r_byte_left;
    logic [7:0]                   r_pend;
    logic                         r_pend_valid;
    logic [ADDRESS_BUS_WIDTH-1:0] r_base;
    logic [15:0]                  r_wc;
    logic [15:0]                  r_words;
    logic                         r_err_hold;

    // Registered outputs
    logic [ADDRESS_BUS_WIDTH-1:0] r_write_address;
    logic [15:0]                  r_write_data;
    logic                         r_write_strobe;
    logic                         r_frame_done;
    logic                         r_frame_error;
    logic [15:0]                  r_pixel_count;
    logic                         r_overflow;

    logic        w_rise, w_bit, w_bit_done, w_end_frame, w_led_frame, w_bad_frame;
    logic        w_timeout, w_to_frame, w_close_ok, w_close_err, w_close;
    logic        w_pack_go, w_flush, w_word_req, w_room;
    logic [31:0] w_sr_next;
    logic [7:0]  w_pack_byte;
    logic [15:0] w_word;

    assign w_rise      = r_clk_sync & ~r_clk_prev;
    assign w_bit       = r_data_sync;
    assign w_sr_next   = {r_sr, w_bit};
    assign w_bit_done  = w_rise && (r_state == ST_FRAME) && (r_bit_cnt == 5'd31);
    assign w_end_frame = w_bit_done && (w_sr_next == 32'hFFFF_FFFF);
    assign w_led_frame = w_bit_done && (w_sr_next[31:29] == 3'b111) && !w_end_frame;
    assign w_bad_frame = w_bit_done && (w_sr_next[31:29] != 3'b111);

    // Timeout fires once, on the cycle the idle count reaches IDLE_TIMEOUT
    assign w_timeout   = !w_rise && (r_idle == c_idle_pre);
    assign w_to_frame  = w_timeout && (r_state == ST_FRAME);
    // A stopped clock on a frame boundary is a strip that omits the end frame
    assign w_close_ok  = w_end_frame || (w_to_frame && (r_bit_cnt == 5'd0));
    assign w_close_err = w_bad_frame || (w_to_frame && (r_bit_cnt != 5'd0));
    assign w_close     = w_close_ok || w_close_err;

    // Byte packer: odd bytes (or a flush) complete a word with the pending byte
    assign w_pack_go   = (r_byte_left != 2'd0);
    assign w_pack_byte = r_pix[23:16];
    assign w_flush     = w_close && r_pend_valid;
    assign w_word_req  = (w_pack_go && r_pend_valid) || w_flush;
    assign w_word      = w_flush ? {r_pend, 8'h00} : {r_pend, w_pack_byte};
    assign w_room      = (r_words != r_wc);

    assign bus.write_address = r_write_address;
    assign bus.write_data    = r_write_data;
    assign bus.write_strobe  = r_write_strobe;
    assign bus.frame_done    = r_frame_done;
    assign bus.frame_error   = r_frame_error;
    assign bus.pixel_count   = r_pixel_count;
    assign bus.overflow      = r_overflow;

    // Two-flop synchronizers on the asynchronous APA102 pair plus edge history
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data_meta <= 1'b0;
            r_data_sync <= 1'b0;
            r_clk_meta  <= 1'b0;
            r_clk_sync  <= 1'b0;
            r_clk_prev  <= 1'b0;
        end else begin
            r_data_meta <= bus.data_in;
            r_data_sync <= r_data_meta;
            r_clk_meta  <= bus.clock_in;
            r_clk_sync  <= r_clk_meta;
            r_clk_prev  <= r_clk_sync;
        end
    end

    // Frame decoder, byte packer and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_HUNT;
            r_zero_cnt      <= '0;
            r_bit_cnt       <= '0;
            r_sr            <= '0;
            r_idle          <= '0;
            r_pix           <= '0;
            r_byte_left     <= '0;
            r_pend          <= '0;
            r_pend_valid    <= 1'b0;
            r_base          <= '0;
            r_wc            <= '0;
            r_words         <= '0;
            r_err_hold      <= 1'b0;
            r_write_address <= '0;
            r_write_data    <= '0;
            r_write_strobe  <= 1'b0;
            r_frame_done    <= 1'b0;
            r_frame_error   <= 1'b0;
            r_pixel_count   <= '0;
            r_overflow      <= 1'b0;
        end else begin
            r_write_strobe <= 1'b0;
            r_frame_done   <= 1'b0;
            r_frame_error  <= 1'b0;

            if (w_rise) begin
                r_idle <= '0;
            end else if (r_idle != c_idle_max) begin
                r_idle <= r_idle + 1'b1;
            end

            // Packer: bytes stream out of r_pix one per clk after an LED frame
            if (w_word_req) begin
                if (w_room) begin
                    r_write_strobe  <= 1'b1;
                    r_write_address <= r_base + ADDRESS_BUS_WIDTH'(r_words);
                    r_write_data    <= w_word;
                    r_words         <= r_words + 16'd1;
                end else begin
                    r_overflow <= 1'b1;
                end
                r_pend_valid <= 1'b0;
            end else if (w_pack_go) begin
                r_pend       <= w_pack_byte;
                r_pend_valid <= 1'b1;
            end
            if (w_pack_go) begin
                r_pix       <= {r_pix[15:0], 8'h00};
                r_byte_left <= r_byte_left - 2'd1;
            end

            case (r_state)
                ST_HUNT: begin
                    if (w_timeout) begin
                        r_zero_cnt <= '0;
                    end else if (w_rise) begin
                        if (w_bit) begin
                            r_zero_cnt <= '0;
                        end else if (r_zero_cnt == 5'd31) begin
                            r_zero_cnt    <= '0;
                            r_state       <= ST_START;
                            r_base        <= ADDRESS_BUS_WIDTH'(bus.start_address);
                            r_wc          <= bus.word_count;
                            r_words       <= '0;
                            r_pixel_count <= '0;
                            r_overflow    <= 1'b0;
                            r_pend_valid  <= 1'b0;
                        end else begin
                            r_zero_cnt <= r_zero_cnt + 5'd1;
                        end
                    end
                end
                ST_START: begin
                    if (w_timeout) begin
                        r_state <= ST_HUNT;
                    end else if (w_rise && w_bit) begin
                        r_state   <= ST_FRAME;
                        r_sr      <= 31'd1;
                        r_bit_cnt <= 5'd1;
                    end
                end
                ST_FRAME: begin
                    if (w_rise) begin
                        r_sr      <= w_sr_next[30:0];
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                    if (w_led_frame) begin
                        r_pixel_count <= r_pixel_count + 16'd1;
                        r_pix         <= w_sr_next[23:0];
                        r_byte_left   <= 2'd3;
                    end
                    if (w_close) begin
                        r_zero_cnt <= '0;
                        if (r_pend_valid) begin
                            // The flush write goes out now; frame_done follows a clk later
                            r_state    <= ST_FLUSH;
                            r_err_hold <= w_close_err;
                        end else begin
                            r_state       <= ST_HUNT;
                            r_frame_done  <= 1'b1;
                            r_frame_error <= w_close_err;
                        end
                    end
                end
                ST_FLUSH: begin
                    r_state       <= ST_HUNT;
                    r_frame_done  <= 1'b1;
                    r_frame_error <= r_err_hold;
                end
                default: r_state <= ST_HUNT;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_apa102_in.sv
`default_nettype none
// ============================================================================
// Module      : tb_apa102_in
// Description : Self-checking bench for apa102_in. A byte-level model turns
//               the LED frames sent into expected memory words and frame
//               results; one compare process checks every write and every
//               frame_done against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apa102_in;
    localparam int AW   = 16;
    localparam int IDLE = 64;

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } wr_t;

    typedef struct packed {
        logic        err;
        logic [15:0] pix;
        logic        ovf;
    } done_t;

    logic clk = 1'b0;
    logic rst;

    apa102_in_if #(.ADDRESS_BUS_WIDTH(AW)) bus ();

    apa102_in #(.ADDRESS_BUS_WIDTH(AW), .IDLE_TIMEOUT(IDLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int n_done   = 0;

    wr_t         exp_wr[$];
    done_t       exp_done[$];
    logic [15:0] mem[logic [15:0]];

    // Model state for the frame in flight
    logic [7:0]  m_bytes[$];
    logic [15:0] m_base;
    int          m_wc;
    int          m_emitted;
    int          m_pix;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic logic [15:0] mem_rd(logic [15:0] a);
        return mem.exists(a) ? mem[a] : 16'hDEAD;
    endfunction

    function automatic void model_push_word(logic [7:0] hi, logic [7:0] lo);
        wr_t w;
        if (m_emitted < m_wc) begin
            w.addr = m_base + 16'(m_emitted);
            w.data = {hi, lo};
            exp_wr.push_back(w);
        end
        m_emitted++;
    endfunction

    task automatic model_start(input logic [15:0] base, input int wc);
        m_bytes.delete();
        m_base    = base;
        m_wc      = wc;
        m_emitted = 0;
        m_pix     = 0;
        bus.start_address = base;
        bus.word_count    = 16'(wc);
    endtask

    // A frame close: leftover odd byte becomes {byte, 00}; then the frame result
    task automatic model_close(input logic err);
        done_t d;
        if (m_bytes.size() > 2 * m_emitted)
            model_push_word(m_bytes[2 * m_emitted], 8'h00);
        d.err = err;
        d.pix = 16'(m_pix);
        d.ovf = (m_emitted > m_wc);
        exp_done.push_back(d);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        bus.data_in  = b;
        bus.clock_in = 1'b0;
        repeat (3) @(negedge clk);
        bus.clock_in = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Model first (writes can appear before the last bit task returns), then the line
    task automatic send_led(input logic [31:0] w);
        m_pix++;
        m_bytes.push_back(w[23:16]);
        m_bytes.push_back(w[15:8]);
        m_bytes.push_back(w[7:0]);
        while (m_bytes.size() >= 2 * (m_emitted + 1))
            model_push_word(m_bytes[2 * m_emitted], m_bytes[2 * m_emitted + 1]);
        send_bits(w, 32);
    endtask

    task automatic send_end();
        model_close(1'b0);
        send_bits(32'hFFFF_FFFF, 32);
    endtask

    task automatic wait_done(input int target, input int budget);
        int k = 0;
        while (n_done < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk("frame_done_count", 32'(n_done), 32'(target));
        chk("writes_drained", 32'(exp_wr.size()), 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_write_address"}, 32'(bus.write_address), 32'd0);
        chk({tag, "_write_data"},    32'(bus.write_data),    32'd0);
        chk({tag, "_write_strobe"},  32'(bus.write_strobe),  32'd0);
        chk({tag, "_frame_done"},    32'(bus.frame_done),    32'd0);
        chk({tag, "_frame_error"},   32'(bus.frame_error),   32'd0);
        chk({tag, "_pixel_count"},   32'(bus.pixel_count),   32'd0);
        chk({tag, "_overflow"},      32'(bus.overflow),      32'd0);
    endtask

    // Compare every write and every frame_done against the model
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.write_strobe) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL write_unexpected: got addr %0h data %0h expected no write",
                             bus.write_address, bus.write_data);
                end else begin
                    wr_t e;
                    e = exp_wr.pop_front();
                    chk("write_address", 32'(bus.write_address), 32'(e.addr));
                    chk("write_data",    32'(bus.write_data),    32'(e.data));
                end
                mem[bus.write_address] = bus.write_data;
            end
            if (bus.frame_done) begin
                n_done++;
                chk("done_with_strobe", 32'(bus.write_strobe), 32'd0);
                if (exp_done.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_unexpected: got frame_done err=%0b expected none",
                             bus.frame_error);
                end else begin
                    done_t d;
                    d = exp_done.pop_front();
                    chk("frame_error", 32'(bus.frame_error), 32'(d.err));
                    chk("pixel_count", 32'(bus.pixel_count), 32'(d.pix));
                    chk("overflow",    32'(bus.overflow),    32'(d.ovf));
                end
            end
        end
    end

    initial begin
        rst               = 1'b1;
        bus.data_in       = 1'b0;
        bus.clock_in      = 1'b0;
        bus.start_address = '0;
        bus.word_count    = '0;
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst = 1'b0;

        // 1: one pixel, flush of R, address wraps 0xFFFF -> 0x0000
        model_start(16'hFFFF, 16);
        send_bits(32'h0, 32);
        send_led(32'hFF10_2030);
        send_end();
        wait_done(1, 2000);
        chk("t1_word0", 32'(mem_rd(16'hFFFF)), 32'h1020);
        chk("t1_word1", 32'(mem_rd(16'h0000)), 32'h3000);

        // 2: two pixels pack into three words, no flush
        model_start(16'h0100, 16);
        send_bits(32'h0, 32);
        send_led(32'hE1AA_BBCC);
        send_led(32'hE1DD_EEFF);
        send_end();
        wait_done(2, 2000);
        chk("t2_word1", 32'(mem_rd(16'h0101)), 32'hCCDD);
        chk("t2_pixel_count", 32'(bus.pixel_count), 32'd2);

        // 3: same with word_count=2 -> third word dropped, overflow
        model_start(16'h0200, 2);
        send_bits(32'h0, 32);
        send_led(32'hE1AA_BBCC);
        send_led(32'hE1DD_EEFF);
        send_end();
        wait_done(3, 2000);
        chk("t3_overflow", 32'(bus.overflow), 32'd1);
        chk("t3_no_third", 32'(mem.exists(16'h0202)), 32'd0);

        // 4: strip without end frame, idle timeout on a frame boundary
        model_start(16'h0300, 16);
        send_bits(32'h0, 32);
        send_led(32'hE001_0203);
        model_close(1'b0);
        wait_done(4, IDLE * 4);
        chk("t4_flush", 32'(mem_rd(16'h0301)), 32'h0300);

        // 5: truncated frame, idle timeout mid-frame
        model_start(16'h0400, 16);
        send_bits(32'h0, 32);
        model_close(1'b1);
        send_bits(32'h0000_E123, 16);
        wait_done(5, IDLE * 4);
        chk("t5_no_write", 32'(mem.exists(16'h0400)), 32'd0);

        // 5b: reset mid-frame clears everything and no frame_done follows
        model_start(16'h0500, 16);
        send_bits(32'h0, 32);
        send_led(32'hE0AA_BBCC);
        send_bits(32'h0000_C0DE, 16);
        chk("t5b_pix_before_rst", 32'(bus.pixel_count), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_outputs_zero("t5b_rst");
        rst = 1'b0;
        repeat (IDLE * 3) @(negedge clk);
        chk("t5b_no_done", 32'(n_done), 32'd5);
        chk("t5b_writes", 32'(exp_wr.size()), 32'd0);

        // 6: bad header -> error, then a normal frame decodes
        model_start(16'h0600, 16);
        send_bits(32'h0, 32);
        model_close(1'b1);
        send_bits(32'h5F00_0000, 32);
        wait_done(6, 2000);
        model_start(16'h0700, 16);
        send_bits(32'h0, 32);
        send_led(32'hE112_3456);
        send_end();
        wait_done(7, 2000);
        chk("t6_word0", 32'(mem_rd(16'h0700)), 32'h1234);
        chk("t6_word1", 32'(mem_rd(16'h0701)), 32'h5600);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
